// File: rtl/jalu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, flag bit positions,
// sequencer states and the latched request record.
package jalu_pkg;

   localparam int W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b001;
   localparam logic [2:0] OP_SHL = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   // Op 111 enables no ALU result path, so it doubles as the idle op.
   localparam logic [2:0] OP_IDLE = OP_CMP;

   localparam int F_C   = 3;
   localparam int F_ALO = 2;
   localparam int F_EQ  = 1;
   localparam int F_Z   = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TMP  = 2'd1,
      EXEC = 2'd2,
      DONE = 2'd3
   } state_e;

   // Everything captured from the requester at acceptance, except B.
   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic         ci;
   } req_t;

endpackage

// File: rtl/jflags.sv
// Flags register {C, ALO, EQ, Z}: full load from the ALU, or clear C alone.
module jflags
   import jalu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clr_c,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] flags_d;
   logic [3:0] flags_q;

   // Next flags: a load from the ALU takes priority over a C clear.
   always_comb begin
      // NOTE: assign a default first so no path through always_comb leaves a latch.
      flags_d = flags_q;
      if (load) begin
         flags_d = d;
      end else if (clr_c) begin
         flags_d[F_C] = 1'b0;
      end
   end

   // Flags storage with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign q = flags_q;

endmodule

// File: rtl/jalu_seq.sv
// Multi-cycle initiator for the external 8-bit combinational ALU.
// Each request runs IDLE -> TMP -> EXEC -> DONE: B is moved into TMP, the
// ALU is driven for one cycle, and its result/flags land in ACC and flags.
module jalu_seq
   import jalu_pkg::*;
(
   input  logic         wclk,
   input  logic         wrst,
   input  logic         wreq,
   output logic         wrdy,
   input  logic [2:0]   bop,
   input  logic [W-1:0] bra,
   input  logic [W-1:0] brb,
   input  logic         wuse_c,
   input  logic         wclrc,
   output logic         wdone,
   output logic [W-1:0] bres,
   output logic [3:0]   bflags,
   output logic [W-1:0] bas,
   output logic [W-1:0] bbs,
   output logic [2:0]   bops,
   output logic         wci,
   input  logic [W-1:0] bcs,
   input  logic         wco,
   input  logic         weqo,
   input  logic         walo,
   input  logic         wz
);

   state_e       state_q, state_d;
   req_t         req_q,   req_d;
   logic [W-1:0] b_q,     b_d;
   logic [W-1:0] tmp_q,   tmp_d;
   logic [W-1:0] acc_q,   acc_d;
   logic         done_q,  done_d;
   logic         flag_load;
   logic [3:0]   flags;

   // Sequencer next-state, request latch, TMP and ACC updates.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      b_d       = b_q;
      tmp_d     = tmp_q;
      acc_d     = acc_q;
      done_d    = 1'b0;
      flag_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (wreq) begin
               // A clear arriving with the request must not leak the old C in.
               req_d.op = bop;
               req_d.a  = bra;
               req_d.ci = wuse_c & flags[F_C] & ~wclrc;
               b_d      = brb;
               state_d  = TMP;
            end
         end
         TMP: begin
            tmp_d   = b_q;
            state_d = EXEC;
         end
         EXEC: begin
            flag_load = 1'b1;
            if (req_q.op != OP_CMP) begin
               acc_d = bcs;
            end
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; reset aborts any operation in flight.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q <= IDLE;
         req_q   <= '0;
         b_q     <= '0;
         tmp_q   <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         b_q     <= b_d;
         tmp_q   <= tmp_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
      end
   end

   // ALU port decode: operands only during EXEC, quiet idle op otherwise.
   always_comb begin
      bas  = '0;
      bbs  = '0;
      bops = OP_IDLE;
      wci  = 1'b0;
      if (state_q == EXEC) begin
         bas  = req_q.a;
         bbs  = tmp_q;
         bops = req_q.op;
         wci  = req_q.ci;
      end
   end

   // The EXEC load always wins over a same-cycle C clear inside jflags.
   jflags u_flags (
      .clk   (wclk),
      .rst   (wrst),
      .load  (flag_load),
      .clr_c (wclrc),
      .d     ({wco, walo, weqo, wz}),
      .q     (flags)
   );

   assign wrdy   = (state_q == IDLE);
   assign wdone  = done_q;
   assign bres   = acc_q;
   assign bflags = flags;

endmodule

// File: tb/tb_jalu_seq.sv
// Scoreboard bench for jalu_seq with a behavioural ALU on its ALU ports.
module tb_jalu_seq;

   logic       wclk = 1'b0;
   logic       wrst, wreq, wuse_c, wclrc;
   logic       wrdy, wdone, wci;
   logic [2:0] bop, bops;
   logic [7:0] bra, brb, bres, bas, bbs, bcs;
   logic [3:0] bflags;
   logic       wco, weqo, walo, wz;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] res;
      logic [3:0] flags;
      int         due;
   } exp_t;
   exp_t sb[$];

   jalu_seq dut (
      .wclk(wclk), .wrst(wrst), .wreq(wreq), .wrdy(wrdy), .bop(bop),
      .bra(bra), .brb(brb), .wuse_c(wuse_c), .wclrc(wclrc), .wdone(wdone),
      .bres(bres), .bflags(bflags), .bas(bas), .bbs(bbs), .bops(bops),
      .wci(wci), .bcs(bcs), .wco(wco), .weqo(weqo), .walo(walo), .wz(wz)
   );

   always #5 wclk = ~wclk;
   always @(posedge wclk) cyc <= cyc + 1;

   // Behavioural ALU: shifts take carry-in at the vacated end.
   always_comb begin
      bcs = 8'h00;
      wco = 1'b0;
      case (bops)
         3'b000: {wco, bcs} = {1'b0, bas} + {1'b0, bbs} + {8'h00, wci};
         3'b001: begin bcs = {wci, bas[7:1]}; wco = bas[0]; end
         3'b010: begin bcs = {bas[6:0], wci}; wco = bas[7]; end
         3'b011: bcs = ~bas;
         3'b100: bcs = bas & bbs;
         3'b101: bcs = bas | bbs;
         3'b110: bcs = bas ^ bbs;
         default: bcs = 8'h00;
      endcase
      weqo = (bas == bbs);
      walo = (bas > bbs);
      wz   = (bcs == 8'h00);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every wdone pulse must match the oldest expected response.
   always @(negedge wclk) begin
      if (wdone === 1'b1) begin
         if (sb.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_res", bres, e.res);
            check("done_flags", bflags, e.flags);
            check("done_cycle", cyc, e.due);
         end
      end
   end

   // Issue one request from a negedge; wreq is held until wrdy is seen.
   // Returns at the negedge of the TMP cycle.
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic usec, input logic clrc,
                        input logic [7:0] eres, input logic [3:0] eflags, input bit push);
      int n = 0;
      bop = op; bra = a; brb = b; wuse_c = usec; wclrc = clrc; wreq = 1'b1;
      while (wrdy !== 1'b1 && n < 50) begin
         @(negedge wclk);
         n++;
      end
      if (n >= 50) check("wrdy_timeout", 32'd0, 32'd1);
      if (push) begin
         exp_t e;
         e.res = eres; e.flags = eflags; e.due = cyc + 3;
         sb.push_back(e);
      end
      @(negedge wclk);
      wreq = 1'b0; wuse_c = 1'b0; wclrc = 1'b0;
      check("busy_wrdy", wrdy, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge wclk);
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(negedge wclk);
   endtask

   initial begin
      wrst = 1'b1; wreq = 1'b0; wuse_c = 1'b0; wclrc = 1'b0;
      bop = 3'b000; bra = 8'h00; brb = 8'h00;
      repeat (3) @(negedge wclk);
      wrst = 1'b0;
      @(negedge wclk);
      check("rst_wrdy", wrdy, 1'b1);
      check("rst_bres", bres, 8'h00);
      check("rst_flags", bflags, 4'h0);
      check("rst_wdone", wdone, 1'b0);
      check("idle_bops", bops, 3'b111);
      check("idle_bas", bas, 8'h00);

      // ADD chain and shifts
      issue(3'b000, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 4'hC, 1'b1);
      drain();
      issue(3'b000, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 4'h4, 1'b1);
      drain();
      issue(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'hD, 1'b1);
      drain();
      issue(3'b010, 8'h81, 8'h00, 1'b1, 1'b0, 8'h03, 4'hC, 1'b1);
      drain();
      issue(3'b001, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 4'hD, 1'b1);
      drain();

      // CMP keeps ACC
      issue(3'b101, 8'h55, 8'h00, 1'b0, 1'b0, 8'h55, 4'h4, 1'b1);
      drain();
      issue(3'b111, 8'h09, 8'h03, 1'b0, 1'b0, 8'h55, 4'h5, 1'b1);
      drain();
      issue(3'b111, 8'h7A, 8'h7A, 1'b0, 1'b0, 8'h55, 4'h3, 1'b1);
      drain();

      // Logic ops
      issue(3'b100, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h42, 4'h4, 1'b1);
      drain();
      issue(3'b101, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'hDB, 4'h4, 1'b1);
      drain();
      issue(3'b110, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h99, 4'h4, 1'b1);
      drain();
      issue(3'b011, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h3C, 4'h4, 1'b1);
      drain();
      check("idle_bops2", bops, 3'b111);
      check("idle_bas2", bas, 8'h00);

      // Back-to-back: second request waits out the busy op
      issue(3'b000, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 4'h2, 1'b1);
      issue(3'b110, 8'h0F, 8'h0F, 1'b0, 1'b0, 8'h00, 4'h3, 1'b1);
      drain();

      // C clear in IDLE
      issue(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'hD, 1'b1);
      drain();
      wclrc = 1'b1;
      @(negedge wclk);
      wclrc = 1'b0;
      check("clrc_idle", bflags, 4'h5);

      // C clear coincident with a carry-using request
      issue(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'hD, 1'b1);
      drain();
      issue(3'b000, 8'h01, 8'h01, 1'b1, 1'b1, 8'h02, 4'h2, 1'b1);
      @(negedge wclk);
      check("exec_wci", wci, 1'b0);
      check("exec_bas", bas, 8'h01);
      check("exec_bops", bops, 3'b000);
      drain();

      // Reset during EXEC aborts the op
      issue(3'b000, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      @(negedge wclk);
      wrst = 1'b1;
      repeat (2) @(negedge wclk);
      wrst = 1'b0;
      @(negedge wclk);
      check("abort_bres", bres, 8'h00);
      check("abort_flags", bflags, 4'h0);
      check("abort_wrdy", wrdy, 1'b1);
      repeat (4) @(negedge wclk);
      check("abort_queue", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
